dbus_cmd_master: RTL and testbench
==================================

Name: dbus_cmd_master

Overview:
- Bus initiator for the VexRiscv-style simple data bus (cmd valid/ready, rsp ready/error/data), i.e. the master side of the protocol the SoC memory/IO decoder answers.
- Driven by a byte stream (from a UART receiver) carrying word read/write commands; returns read data and status on an outgoing byte stream (to a UART transmitter).
- Used for host-side program loading into RISC-V RAM and for IO register poking/debug while the CPU is held in reset.

Parameters:
- WL, 32, bus data/address width in bits; fixed at 32 (4 bytes per word).
- BYTE_TIMEOUT, 1000000, idle cycles allowed between bytes of one command before abort.
- RSP_TIMEOUT, 1024, cycles allowed from read cmd handshake to rsp_ready before NAK.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  command byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_data  out  8  reply byte
- out_valid  out  1  reply byte valid, held until accepted
- out_ready  in  1  sink accepts out_data
- dbus_cmd_valid  out  1  command request
- dbus_cmd_ready  in  1  responder accepts command
- dbus_cmd_wr  out  1  1 = write, 0 = read
- dbus_cmd_address  out  WL  byte address, bits [1:0] always 0
- dbus_cmd_data  out  WL  write data
- dbus_cmd_size  out  2  always 2'b10 (word)
- dbus_rsp_ready  in  1  read data valid strobe
- dbus_rsp_error  in  1  read error, sampled with dbus_rsp_ready
- dbus_rsp_data  in  WL  read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_data=0, dbus_cmd_valid=0, dbus_cmd_wr=0, address/data=0, busy=0; state=IDLE.
- Reset asserted mid-command or mid-transaction aborts immediately; no reply byte is emitted for the aborted command.
- Command framing, multi-byte fields little-endian:
  - 0x57 'W': opcode + 4 address bytes + 4 data bytes.
  - 0x52 'R': opcode + 4 address bytes.
- Replies:
  - Write: one status byte, 0x06 ACK.
  - Read: 4 data bytes LSB first, then status byte ACK, or 0x15 NAK on rsp error or timeout. On timeout the data bytes are 0x00.
  - Unknown opcode: single NAK byte.
- FSM states:
  - IDLE: in_ready=1. Accept opcode → ADDR (W/R) or STAT with NAK.
  - ADDR: in_ready=1. Shift 4 bytes, 2-bit counter. After byte 3 → DATA (W) or CMD (R).
  - DATA: in_ready=1. Shift 4 bytes → CMD.
  - CMD: dbus_cmd_valid=1, fields stable until dbus_cmd_valid && dbus_cmd_ready. Then write → STAT(ACK); read → WAIT_RSP.
  - WAIT_RSP: counter runs. dbus_rsp_ready → latch data, error → TXD. Counter reaches RSP_TIMEOUT-1 → data=0, NAK → TXD.
  - TXD: emit 4 bytes LSB first, each held until out_ready → STAT.
  - STAT: emit status byte, hold until out_ready → IDLE.
- in_ready is 0 in CMD, WAIT_RSP, TXD and STAT; the source is stalled.
- Inter-byte timeout: in ADDR or DATA, BYTE_TIMEOUT cycles with no accepted byte → IDLE, no reply, partial fields discarded. Counter clears on every accepted byte.
- Handshake timing:
  - dbus_cmd_valid rises the cycle after the last command byte.
  - Minimum write turnaround: handshake in the first CMD cycle, ACK out_valid on the next cycle.
- Address bits [1:0] are forced to 0 on the bus.
- Responses not in WAIT_RSP (stray dbus_rsp_ready) are ignored.
- A rsp_ready in the same cycle as timeout expiry counts as a valid response.

Decomposition:
- Package dbus_cmd_pkg:
  - opcode constants OP_WRITE=8'h57, OP_READ=8'h52.
  - ACK=8'h06, NAK=8'h15.
  - DBUS_SIZE_WORD=2'b10.
  - enum state_t {IDLE, ADDR, DATA, CMD, WAIT_RSP, TXD, STAT}.
- No sub-module. A single shared down-counter serves both timeouts, since they never run concurrently.

Test Plan:
- Write: bytes 57 10 00 00 00 EF BE AD DE, cmd_ready=1 → one handshake with wr=1, address=0x00000010, data=0xDEADBEEF, size=2; then one 0x06 reply.
- Read with stall: 52 04 00 00 80, cmd_ready low for 3 cycles, rsp_ready 2 cycles after handshake with data 0x12345678, error=0 → cmd_valid held 4 cycles; replies 78 56 34 12 06.
- Read error/timeout:
  - rsp_error=1 → data bytes then 0x15.
  - No rsp for RSP_TIMEOUT cycles → 00 00 00 00 15.
- Bad opcode 0xAA → single 0x15 reply; next valid write completes normally. Address 0x00000013 → bus address 0x00000010.
- Backpressure and mid-command abort: out_ready toggled randomly → byte order and values intact, no duplicates. Byte gap > BYTE_TIMEOUT after 2 address bytes → no reply, no bus cmd, next command parses from opcode.
- Async reset: reset pulsed during CMD and during TXD → outputs at reset values the same cycle with no clock edge, busy=0, no stray bytes afterwards.

Source files
------------

// File: rtl/dbus_cmd_pkg.sv
// Shared constants and state encoding for the byte-stream-driven data bus master.
// Opcodes, reply codes and bus size are fixed by the host protocol.
package dbus_cmd_pkg;

    localparam logic [7:0] OP_WRITE       = 8'h57;
    localparam logic [7:0] OP_READ        = 8'h52;
    localparam logic [7:0] ACK            = 8'h06;
    localparam logic [7:0] NAK            = 8'h15;
    localparam logic [1:0] DBUS_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CMD,
        WAIT_RSP,
        TXD,
        STAT
    } state_t;

endpackage

// File: rtl/dbus_cmd_master.sv
// Parses 'W'/'R' word commands from a byte stream, runs them on the simple data bus, replies on a byte stream.
// Latency: cmd_valid the cycle after the last command byte; reply bytes held until out_ready; in_ready low while busy.
module dbus_cmd_master
    import dbus_cmd_pkg::*;
#(
    parameter int WL           = 32,
    parameter int BYTE_TIMEOUT = 1000000,
    parameter int RSP_TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          dbus_cmd_valid,
    input  logic          dbus_cmd_ready,
    output logic          dbus_cmd_wr,
    output logic [WL-1:0] dbus_cmd_address,
    output logic [WL-1:0] dbus_cmd_data,
    output logic [1:0]    dbus_cmd_size,
    input  logic          dbus_rsp_ready,
    input  logic          dbus_rsp_error,
    input  logic [WL-1:0] dbus_rsp_data,
    output logic          busy
);

    localparam int CNT_MAX = (BYTE_TIMEOUT > RSP_TIMEOUT) ? BYTE_TIMEOUT : RSP_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BYTE_LOAD = CW'(BYTE_TIMEOUT - 1);
    localparam logic [CW-1:0] RSP_LOAD  = CW'(RSP_TIMEOUT - 1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_idx;
    logic           r_wr;
    logic [WL-1:0]  r_addr;
    logic [WL-1:0]  r_data;
    logic [WL-1:0]  r_rdata;
    logic [7:0]     r_status;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [7:0]     r_out_data;
    logic           r_cmd_valid;
    logic           r_busy;

    logic w_in_fire;
    logic w_out_fire;
    logic w_cmd_fire;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_cmd_fire = r_cmd_valid && dbus_cmd_ready;

    // One down-counter times both the inter-byte gap and the read response wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_status    <= 8'h00;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    if (w_in_fire) begin
                        r_idx  <= '0;
                        r_cnt  <= BYTE_LOAD;
                        r_busy <= 1'b1;
                        if (in_data == OP_WRITE || in_data == OP_READ) begin
                            r_wr    <= (in_data == OP_WRITE);
                            r_state <= ADDR;
                        end else begin
                            r_status    <= NAK;
                            r_out_data  <= NAK;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= STAT;
                        end
                    end
                end
                ADDR: begin
                    if (w_in_fire) begin
                        r_cnt <= BYTE_LOAD;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            // Last byte: low address bits are dropped so the bus only sees word addresses.
                            r_addr <= {in_data, r_addr[WL-1:10], 2'b00};
                            if (r_wr) begin
                                r_state <= DATA;
                            end else begin
                                r_cmd_valid <= 1'b1;
                                r_in_ready  <= 1'b0;
                                r_state     <= CMD;
                            end
                        end else begin
                            r_addr <= {in_data, r_addr[WL-1:8]};
                        end
                    end else if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (w_in_fire) begin
                        r_cnt  <= BYTE_LOAD;
                        r_idx  <= r_idx + 2'd1;
                        r_data <= {in_data, r_data[WL-1:8]};
                        if (r_idx == 2'd3) begin
                            r_cmd_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= CMD;
                        end
                    end else if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                CMD: begin
                    if (w_cmd_fire) begin
                        r_cmd_valid <= 1'b0;
                        if (r_wr) begin
                            r_status    <= ACK;
                            r_out_data  <= ACK;
                            r_out_valid <= 1'b1;
                            r_state     <= STAT;
                        end else begin
                            r_cnt   <= RSP_LOAD;
                            r_state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response on the expiry cycle still wins over the timeout.
                    if (dbus_rsp_ready) begin
                        r_rdata     <= {8'h00, dbus_rsp_data[WL-1:8]};
                        r_out_data  <= dbus_rsp_data[7:0];
                        r_status    <= dbus_rsp_error ? NAK : ACK;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= TXD;
                    end else if (r_cnt == '0) begin
                        r_rdata     <= '0;
                        r_out_data  <= 8'h00;
                        r_status    <= NAK;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= TXD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                TXD: begin
                    if (w_out_fire) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_out_data <= r_status;
                            r_state    <= STAT;
                        end else begin
                            r_out_data <= r_rdata[7:0];
                            r_rdata    <= {8'h00, r_rdata[WL-1:8]};
                        end
                    end
                end
                STAT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign dbus_cmd_valid   = r_cmd_valid;
    assign dbus_cmd_wr      = r_wr;
    assign dbus_cmd_address = r_addr;
    assign dbus_cmd_data    = r_data;
    assign dbus_cmd_size    = DBUS_SIZE_WORD;
    assign busy             = r_busy;

endmodule

// File: tb/tb_dbus_cmd_master.sv
// Randomized scoreboard bench for dbus_cmd_master with a bus responder and a reply-byte monitor.
module tb_dbus_cmd_master;
    import dbus_cmd_pkg::*;

    localparam int BT = 40;
    localparam int RT = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        dbus_cmd_valid;
    logic        dbus_cmd_ready = 1'b0;
    logic        dbus_cmd_wr;
    logic [31:0] dbus_cmd_address;
    logic [31:0] dbus_cmd_data;
    logic [1:0]  dbus_cmd_size;
    logic        dbus_rsp_ready = 1'b0;
    logic        dbus_rsp_error = 1'b0;
    logic [31:0] dbus_rsp_data = 32'h0;
    logic        busy;

    always #5 clk = ~clk;

    dbus_cmd_master #(.WL(32), .BYTE_TIMEOUT(BT), .RSP_TIMEOUT(RT)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_address(dbus_cmd_address),
        .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_size(dbus_cmd_size),
        .dbus_rsp_ready(dbus_rsp_ready), .dbus_rsp_error(dbus_rsp_error),
        .dbus_rsp_data(dbus_rsp_data), .busy(busy)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        int          dly;
        logic [31:0] rdata;
        logic        err;
        logic        norsp;
    } plan_t;

    logic [7:0] exp_out[$];
    plan_t      plan_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ordy_mode = 1;   // 0 = hold low, 1 = always ready, 2 = random
    bit         rsp_in_cmd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : ordy_drv
        forever begin
            @(posedge clk);
            #1;
            case (ordy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : out_monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got %02h expected no byte at %0t", out_data, $time);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_byte", out_data, e);
                end
            end
        end
    end

    initial begin : responder
        plan_t p;
        int    stall_left;
        int    hold;
        stall_left = 0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!reset && dbus_cmd_valid) begin
                if (plan_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bus_unexpected: got cmd addr %08h expected none", dbus_cmd_address);
                    dbus_cmd_ready = 1'b1;
                    @(posedge clk);
                    #1 dbus_cmd_ready = 1'b0;
                end else begin
                    if (!rsp_in_cmd) begin
                        rsp_in_cmd = 1'b1;
                        stall_left = plan_q[0].stall;
                        hold = 0;
                    end
                    hold++;
                    if (stall_left > 0) begin
                        stall_left--;
                        dbus_cmd_ready = 1'b0;
                    end else begin
                        dbus_cmd_ready = 1'b1;
                        p = plan_q.pop_front();
                        rsp_in_cmd = 1'b0;
                        chk("cmd_wr", dbus_cmd_wr, p.wr);
                        chk("cmd_addr", dbus_cmd_address, p.addr);
                        if (p.wr) chk("cmd_data", dbus_cmd_data, p.data);
                        chk("cmd_size", dbus_cmd_size, 2'b10);
                        chk("cmd_hold", hold, p.stall + 1);
                        chk("busy_in_cmd", busy, 1'b1);
                        @(posedge clk);
                        #1 dbus_cmd_ready = 1'b0;
                        if (p.wr) begin
                            chk("ack_turnaround", out_valid, 1'b1);
                        end else if (!p.norsp) begin
                            repeat (p.dly) @(posedge clk);
                            #1;
                            dbus_rsp_ready = 1'b1;
                            dbus_rsp_error = p.err;
                            dbus_rsp_data  = p.rdata;
                            @(posedge clk);
                            #1;
                            dbus_rsp_ready = 1'b0;
                            dbus_rsp_error = 1'b0;
                            dbus_rsp_data  = $urandom;
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 for byte %02h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Reference model: expected bus command and reply bytes derived from the protocol rules.
    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int stall, input int dly, input logic [31:0] rdata,
                         input logic err, input logic norsp, input int gapmax);
        plan_t      p;
        logic [7:0] bytes[$];
        bit         is_bus;
        is_bus = (op == OP_WRITE) || (op == OP_READ);
        bytes.push_back(op);
        if (is_bus) begin
            p.wr = (op == OP_WRITE);
            p.addr = addr & ~32'h3;
            p.data = data;
            p.stall = stall;
            p.dly = dly;
            p.rdata = rdata;
            p.err = err;
            p.norsp = norsp;
            plan_q.push_back(p);
            for (int i = 0; i < 4; i++) bytes.push_back(8'((addr >> (8 * i)) & 32'hFF));
            if (p.wr) begin
                for (int i = 0; i < 4; i++) bytes.push_back(8'((data >> (8 * i)) & 32'hFF));
                exp_out.push_back(ACK);
            end else if (norsp) begin
                for (int i = 0; i < 4; i++) exp_out.push_back(8'h00);
                exp_out.push_back(NAK);
            end else begin
                for (int i = 0; i < 4; i++) exp_out.push_back(8'((rdata >> (8 * i)) & 32'hFF));
                exp_out.push_back(err ? NAK : ACK);
            end
        end else begin
            exp_out.push_back(NAK);
        end
        foreach (bytes[i]) send_byte(bytes[i], (i == 0) ? 0 : $urandom_range(0, gapmax));
        if (is_bus) chk("cmd_valid_rise", dbus_cmd_valid, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_out.size() != 0 || plan_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_cmp++;
        if (exp_out.size() != 0 || plan_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d bytes %0d cmds pending expected 0 0", exp_out.size(), plan_q.size());
        end
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 8'h00);
        chk({tag, "_cmd_valid"}, dbus_cmd_valid, 1'b0);
        chk({tag, "_cmd_wr"}, dbus_cmd_wr, 1'b0);
        chk({tag, "_cmd_addr"}, dbus_cmd_address, 32'h0);
        chk({tag, "_cmd_data"}, dbus_cmd_data, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        exp_out.delete();
        plan_q.delete();
        rsp_in_cmd = 1'b0;
        dbus_cmd_ready = 1'b0;
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no completion expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [7:0]  op;
        logic [31:0] a, d;
        int          t;
        #2;
        reset_pulse("rst");
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1'b1);

        // Basic write, stalled read, error read, timeout read.
        issue(OP_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0, 1'b0, 0);
        drain();
        issue(OP_READ, 32'h8000_0004, 32'h0, 3, 2, 32'h1234_5678, 1'b0, 1'b0, 0);
        drain();
        issue(OP_READ, 32'h0000_0100, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 0);
        drain();
        issue(OP_READ, 32'h0000_0200, 32'h0, 1, 0, 32'h0, 1'b0, 1'b1, 0);
        drain();

        // Bad opcode then a write with unaligned address.
        issue(8'hAA, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 0);
        issue(OP_WRITE, 32'h0000_0013, 32'h0BAD_F00D, 0, 0, 32'h0, 1'b0, 1'b0, 0);
        drain();

        // Byte gap beyond the inter-byte limit abandons the partial command silently.
        send_byte(OP_READ, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        repeat (BT + 20) @(posedge clk);
        #1;
        chk("gap_busy", busy, 1'b0);
        chk("gap_in_ready", in_ready, 1'b1);
        dbus_rsp_ready = 1'b1;
        dbus_rsp_error = 1'b1;
        @(posedge clk);
        #1;
        dbus_rsp_ready = 1'b0;
        dbus_rsp_error = 1'b0;
        issue(OP_READ, 32'h0000_0044, 32'h0, 0, 0, 32'hA5A5_1234, 1'b0, 1'b0, 0);
        drain();

        // Reset while the command is stalled on the bus.
        issue(OP_WRITE, 32'h0000_0080, 32'h1111_2222, 20, 0, 32'h0, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_cmd_valid", dbus_cmd_valid, 1'b1);
        #1;
        reset_pulse("rst_cmd");

        // Reset while read data is being returned.
        ordy_mode = 0;
        issue(OP_READ, 32'h0000_0090, 32'h0, 0, 0, 32'h7777_8888, 1'b0, 1'b0, 0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("txd_reached", out_valid, 1'b1);
        @(posedge clk);
        #2;
        reset_pulse("rst_txd");
        ordy_mode = 2;
        issue(OP_WRITE, 32'h0000_00A0, 32'h3333_4444, 0, 0, 32'h0, 1'b0, 1'b0, 0);
        drain();

        // Random traffic under random reply backpressure.
        for (int n = 0; n < 40; n++) begin
            t = $urandom_range(0, 9);
            a = $urandom;
            d = $urandom;
            if (t == 0) begin
                op = 8'($urandom_range(0, 255));
                if (op == OP_WRITE || op == OP_READ) op = 8'hAA;
            end else if (t <= 4) begin
                op = OP_WRITE;
            end else begin
                op = OP_READ;
            end
            issue(op, a, d, $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 3);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
